// File: rtl/branch_resolve_unit.sv
// In-order tracker of in-flight gshare predictions; trains the PHT on resolve,
// redirects fetch and flushes younger entries on a misprediction.
module branch_resolve_unit #(
    parameter int IDX_W  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enq_valid_i,
    output logic              enq_ready_o,
    input  logic [IDX_W-1:0]  enq_index_i,
    input  logic              enq_pred_take_i,
    input  logic [ADDR_W-1:0] enq_pred_target_i,
    input  logic [ADDR_W-1:0] enq_pc_i,
    input  logic              res_valid_i,
    input  logic              res_take_i,
    input  logic [ADDR_W-1:0] res_target_i,
    output logic              res_ready_o,
    input  logic              flush_i,
    output logic              upd_wen_o,
    output logic [IDX_W-1:0]  upd_windex_o,
    output logic              upd_take_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              mispredict_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_miss_o
);
    localparam logic [ADDR_W-1:0] DSLOT_OFF = ADDR_W'(8);

    logic [IDX_W-1:0]  idx_mem [DEPTH];
    logic              pt_mem  [DEPTH];
    logic [ADDR_W-1:0] tgt_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              upd_wen_q, upd_take_q, redirect_q;
    logic [IDX_W-1:0]  upd_windex_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [31:0]       stat_br_q, stat_miss_q;

    logic              enq_fire, res_fire, miss;
    logic [ADDR_W-1:0] correct_pc;

    assign enq_ready_o = (count_q != CNT_W'(DEPTH));
    assign res_ready_o = (count_q != '0);
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign res_fire    = res_valid_i && res_ready_o;

    assign miss = (pt_mem[rd_ptr_q] != res_take_i) ||
                  (res_take_i && pt_mem[rd_ptr_q] && (tgt_mem[rd_ptr_q] != res_target_i));
    // Not-taken branches fall through past the delay slot.
    assign correct_pc = res_take_i ? res_target_i : pc_mem[rd_ptr_q] + DSLOT_OFF;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(res_fire);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_fire);
        count_d  = count_q + CNT_W'(enq_fire) - CNT_W'(res_fire);
        // Flush or mispredict empties the queue and drops any wrong-path enqueue.
        if (flush_i || (res_fire && miss)) begin
            wr_ptr_d = rd_ptr_d;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            idx_mem[wr_ptr_q] <= enq_index_i;
            pt_mem[wr_ptr_q]  <= enq_pred_take_i;
            tgt_mem[wr_ptr_q] <= enq_pred_target_i;
            pc_mem[wr_ptr_q]  <= enq_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_wen_q     <= 1'b0;
            upd_take_q    <= 1'b0;
            upd_windex_q  <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            stat_br_q     <= '0;
            stat_miss_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            upd_wen_q  <= res_fire;
            redirect_q <= res_fire && miss && !flush_i;
            if (res_fire) begin
                upd_windex_q <= idx_mem[rd_ptr_q];
                upd_take_q   <= res_take_i;
                if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
                if (miss && stat_miss_q != '1) stat_miss_q <= stat_miss_q + 32'd1;
                if (miss && !flush_i) redirect_pc_q <= correct_pc;
            end
        end
    end

    assign upd_wen_o        = upd_wen_q;
    assign upd_windex_o     = upd_windex_q;
    assign upd_take_o       = upd_take_q;
    assign redirect_valid_o = redirect_q;
    assign mispredict_o     = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign count_o          = count_q;
    assign stat_branches_o  = stat_br_q;
    assign stat_miss_o      = stat_miss_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: a reference queue predicts each resolve's training/redirect
// result, which is compared one cycle later against the DUT outputs.
module tb_branch_resolve_unit;
    localparam int IDX_W = 8, DEPTH = 4, ADDR_W = 32, CNT_W = 3;

    logic clk = 1'b0, resetn = 1'b0;
    logic enq_valid = 0, enq_pred_take = 0, res_valid = 0, res_take = 0, flush = 0;
    logic [IDX_W-1:0] enq_index = '0;
    logic [ADDR_W-1:0] enq_pred_target = '0, enq_pc = '0, res_target = '0;
    logic enq_ready, res_ready, upd_wen, upd_take, redirect_valid, mispredict;
    logic [IDX_W-1:0] upd_windex;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0] count;
    logic [31:0] stat_branches, stat_miss;

    branch_resolve_unit #(.IDX_W(IDX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_index_i(enq_index),
        .enq_pred_take_i(enq_pred_take), .enq_pred_target_i(enq_pred_target), .enq_pc_i(enq_pc),
        .res_valid_i(res_valid), .res_take_i(res_take), .res_target_i(res_target),
        .res_ready_o(res_ready), .flush_i(flush),
        .upd_wen_o(upd_wen), .upd_windex_o(upd_windex), .upd_take_o(upd_take),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .mispredict_o(mispredict),
        .count_o(count), .stat_branches_o(stat_branches), .stat_miss_o(stat_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic pt;
        logic [ADDR_W-1:0] tgt, pc;
    } ent_t;
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic take, redir;
        logic [ADDR_W-1:0] pc;
    } resp_t;

    ent_t  mq[$];
    resp_t sb[$];
    int    n_tests = 0, n_fail = 0;
    logic [31:0] m_br = 0, m_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model one clock edge with the inputs currently driven, then check outputs.
    task automatic step();
        bit rf, ef, ms;
        ent_t e;
        resp_t r, p;
        chk("enq_ready", 32'(enq_ready), 32'(mq.size() != DEPTH));
        chk("res_ready", 32'(res_ready), 32'(mq.size() != 0));
        rf = res_valid && mq.size() != 0;
        ef = enq_valid && mq.size() != DEPTH;
        ms = 0;
        if (!resetn) begin
            mq.delete(); sb.delete(); m_br = 0; m_miss = 0;
        end else begin
            if (rf) begin
                e = mq[0];
                ms = (e.pt != res_take) || (res_take && e.pt && e.tgt != res_target);
                r.idx = e.idx; r.take = res_take; r.redir = ms && !flush;
                r.pc = res_take ? res_target : e.pc + 32'd8;
                sb.push_back(r);
                if (m_br != '1) m_br++;
                if (ms && m_miss != '1) m_miss++;
                void'(mq.pop_front());
            end
            if (flush || ms) mq.delete();
            else if (ef) begin
                e.idx = enq_index; e.pt = enq_pred_take; e.tgt = enq_pred_target; e.pc = enq_pc;
                mq.push_back(e);
            end
        end
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            p = sb.pop_front();
            chk("upd_wen", 32'(upd_wen), 1);
            chk("upd_windex", 32'(upd_windex), 32'(p.idx));
            chk("upd_take", 32'(upd_take), 32'(p.take));
            chk("redirect_valid", 32'(redirect_valid), 32'(p.redir));
            chk("mispredict", 32'(mispredict), 32'(p.redir));
            if (p.redir) chk("redirect_pc", redirect_pc, p.pc);
        end else begin
            chk("upd_wen_idle", 32'(upd_wen), 0);
            chk("redirect_idle", 32'(redirect_valid), 0);
            chk("mispredict_idle", 32'(mispredict), 0);
        end
        if (!resetn) begin
            chk("rst_windex", 32'(upd_windex), 0);
            chk("rst_take", 32'(upd_take), 0);
            chk("rst_redirect_pc", redirect_pc, 0);
        end
        chk("count", 32'(count), 32'(mq.size()));
        chk("stat_branches", stat_branches, m_br);
        chk("stat_miss", stat_miss, m_miss);
        @(negedge clk);
        enq_valid = 0; res_valid = 0; flush = 0; resetn = 1;
    endtask

    task automatic enq(input logic [7:0] idx, input logic pt, input logic [31:0] tgt, input logic [31:0] pc);
        enq_valid = 1; enq_index = idx; enq_pred_take = pt; enq_pred_target = tgt; enq_pc = pc;
    endtask

    task automatic res(input logic tk, input logic [31:0] tgt);
        res_valid = 1; res_take = tk; res_target = tgt;
    endtask

    initial begin
        @(negedge clk);
        resetn = 0; step();
        resetn = 0; step();
        // correctly predicted taken branch
        enq(8'h3A, 1, 32'hBFC00100, 32'hBFC00040); step();
        res(1, 32'hBFC00100); step();
        // predicted taken, actually not taken: redirect to pc+8
        enq(8'h11, 1, 32'h80000100, 32'h80000010); step();
        res(0, 32'h0); step();
        // target mismatch with three in flight and a same-cycle enqueue
        enq(8'h21, 1, 32'h1000, 32'h400); step();
        enq(8'h22, 0, 32'h0, 32'h404); step();
        enq(8'h23, 0, 32'h0, 32'h408); step();
        res(1, 32'h2000); enq(8'h24, 0, 32'h0, 32'h40C); step();
        res(0, 32'h0); step();
        // fill, then resolve+enqueue while full
        for (int i = 0; i < DEPTH; i++) begin
            enq(8'(8'h40 + i), 0, 32'h0, 32'(32'h100 + 4 * i)); step();
        end
        res(0, 32'h0); enq(8'h50, 0, 32'h0, 32'h200); step();
        // steady stream through pointer wrap
        for (int i = 0; i < 10; i++) begin
            res(mq[0].pt, mq[0].tgt);
            enq(8'(8'h60 + i), 1'(i), 32'(32'h3000 + 16 * i), 32'(32'h500 + 4 * i));
            step();
        end
        while (mq.size() != 0) begin res(mq[0].pt, mq[0].tgt); step(); end
        // flush with a mispredicting resolve: train but no redirect
        enq(8'h05, 0, 32'h0, 32'h600); step();
        enq(8'h06, 0, 32'h0, 32'h604); step();
        res(1, 32'h7000); flush = 1; enq(8'h07, 0, 32'h0, 32'h608); step();
        // flush alone on a non-empty queue
        enq(8'h08, 1, 32'h900, 32'h800); step();
        flush = 1; step();
        res(1, 32'h900); step();
        // reset right after a mispredicting resolve, and coincident with one
        enq(8'h09, 1, 32'hA00, 32'hA04); step();
        res(0, 32'h0); step();
        resetn = 0; step();
        enq(8'h0A, 1, 32'hB00, 32'hB04); step();
        res(0, 32'h0); resetn = 0; step();
        res(1, 32'h1234); step();
        step();
        if (sb.size() != 0) chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
